intr_ctrl: RTL and testbench
============================

INTR_CTRL -- requirements
Module: intr_ctrl

Interface
REQ-001 The block SHALL have parameter N_SRC, default 8, giving the number of interrupt sources (2..16).
REQ-002 The block SHALL have parameter CW, default $clog2(N_SRC), giving the cause-field width.
REQ-003 The block SHALL have port clk  input  1  system clock; all state changes on its rising edge.
REQ-004 The block SHALL have port RST  input  1  reset, synchronous, active-high.
REQ-005 The block SHALL have port irq_in  input  N_SRC  asynchronous level interrupt lines, rising edge = request.
REQ-006 The block SHALL have port mask_wr  input  1  one-cycle strobe to load the enable mask.
REQ-007 The block SHALL have port mask_data  input  N_SRC  new enable mask; bit i = 1 enables source i.
REQ-008 The block SHALL have port mie  input  1  global machine interrupt enable (CSR level).
REQ-009 The block SHALL have port taken  input  1  one-cycle strobe from the control unit that it entered the trap sequence.
REQ-010 The block SHALL have port mret  input  1  one-cycle strobe that the handler executed MRET.
REQ-011 The block SHALL have port intr  output  1  interrupt request to the control unit FSM.
REQ-012 The block SHALL have port cause  output  CW  index of the source being requested or serviced.
REQ-013 The block SHALL have port pending  output  N_SRC  pending-bit register, readable by software.
REQ-014 The block SHALL have port in_isr  output  1  high while a handler is active.

Function
REQ-015 Each irq_in bit SHALL pass through a 2-flop synchronizer followed by a third flop for rising-edge detection.
REQ-016 A 0->1 on synchronized irq_in[i] SHALL set pending[i] exactly 3 rising clk edges after the first edge sampling irq_in[i]=1; a level held high SHALL NOT re-set pending.
REQ-017 The FSM SHALL have two states: ST_RUN (interrupts accepted) and ST_ISR (handler active; in_isr=1).
REQ-018 The requestable vector SHALL be req = pending & mask; cause SHALL be the lowest set index of req (index 0 = highest priority) in ST_RUN.
REQ-019 intr SHALL equal (PS==ST_RUN) & mie & |req, decoded from registers only with no input-to-output combinational path.
REQ-020 In ST_RUN, taken with intr=1 SHALL clear pending[cause], latch cause into cause_q, and move to ST_ISR on the same edge.
REQ-021 In ST_ISR, cause SHALL output cause_q and intr SHALL be 0.
REQ-022 taken with intr=0 SHALL be ignored.
REQ-023 mret in ST_ISR SHALL return to ST_RUN; mret in ST_RUN SHALL be ignored.
REQ-024 When a new edge sets and taken clears the same pending bit on the same edge, set SHALL win.
REQ-025 mask_wr SHALL update mask on the next edge; when it coincides with taken, the clear SHALL use the cause computed from the old mask.
REQ-026 Masked or mie=0 sources SHALL stay pending and raise intr once enabled.
REQ-027 taken and mret asserted together SHALL be resolved by state: in ST_RUN only taken acts; in ST_ISR only mret acts.

Reset
REQ-028 While RST=1 at a clk edge: pending=0, mask=0, all synchronizer and edge flops=0, cause_q=0, PS=ST_RUN; outputs: intr=0, cause=0, pending=0, in_isr=0.
REQ-029 A source already high at reset release SHALL be treated as a rising edge and set pending 3 edges later.
REQ-030 RST asserted mid-handler SHALL abandon ST_ISR and discard all pending requests.

Structure
REQ-031 The state enum and the N_SRC default SHALL live in shared package otter_pkg.
REQ-032 The per-source synchronizer and edge detector SHALL be sub-module sync_edge_det, instantiated N_SRC times.

Verification
REQ-033 With mask=8'hFF and mie=1, irq_in[3] rising -> pending=8'h08 and intr=1 after 3 edges; taken -> pending=0, in_isr=1, cause=3, intr=0.
REQ-034 With irq_in[5] and irq_in[2] rising in the same cycle -> cause=2; after taken then mret -> intr=1 with cause=5.
REQ-035 With mask=8'h00, irq_in[1] rising -> pending=8'h02 and intr=0; mask_wr with 8'h02 -> intr=1 on the next cycle.
REQ-036 A new edge on irq_in[4] landing on the same edge as taken for cause=4 -> pending[4] remains 1 and the FSM enters ST_ISR.
REQ-037 RST pulse while in_isr=1 with pending=8'h10 -> all outputs 0 and PS=ST_RUN the next cycle.
REQ-038 taken with intr=0, or mret in ST_RUN -> no change to any register.

Source files
------------

// File: rtl/otter_pkg.sv
// Shared definitions for the interrupt controller slice: FSM encoding and default source count.
package otter_pkg;

  localparam int N_SRC_DEFAULT = 8;

  typedef enum logic {
    ST_RUN = 1'b0,
    ST_ISR = 1'b1
  } intr_state_t;

endpackage

// File: rtl/sync_edge_det.sv
// Two-flop synchronizer for one asynchronous level line, plus a third flop for rising-edge detection.
module sync_edge_det (
  input  logic clk,
  input  logic RST,
  input  logic din,
  output logic rise
);

  logic s1;
  logic s2;
  logic s3;

  always_ff @(posedge clk) begin
    if (RST) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= din;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign rise = s2 & ~s3;

endmodule

// File: rtl/intr_ctrl.sv
// Interrupt controller: per-source edge capture into pending bits, fixed priority (index 0 highest),
// two-state run/handler FSM handshaking with the control unit via taken/mret.
module intr_ctrl
  import otter_pkg::*;
#(
  parameter int N_SRC = N_SRC_DEFAULT,
  parameter int CW    = $clog2(N_SRC)
) (
  input  logic             clk,
  input  logic             RST,
  input  logic [N_SRC-1:0] irq_in,
  input  logic             mask_wr,
  input  logic [N_SRC-1:0] mask_data,
  input  logic             mie,
  input  logic             taken,
  input  logic             mret,
  output logic             intr,
  output logic [CW-1:0]    cause,
  output logic [N_SRC-1:0] pending,
  output logic             in_isr
);

  intr_state_t      ps;
  intr_state_t      ns;
  logic [N_SRC-1:0] rise;
  logic [N_SRC-1:0] mask;
  logic [N_SRC-1:0] req;
  logic [N_SRC-1:0] clr;
  logic [CW-1:0]    cause_run;
  logic [CW-1:0]    cause_q;
  logic             mie_q;
  logic             fire;
  logic             found;

  for (genvar g = 0; g < N_SRC; g++) begin : g_sync
    sync_edge_det u_sync (
      .clk  (clk),
      .RST  (RST),
      .din  (irq_in[g]),
      .rise (rise[g])
    );
  end

  assign req = pending & mask;

  always_comb begin
    cause_run = '0;
    found     = 1'b0;
    for (int unsigned i = 0; i < N_SRC; i++) begin
      if (req[i] && !found) begin
        cause_run = CW'(i);
        found     = 1'b1;
      end
    end
  end

  // mie is registered so intr is decoded purely from state, with no input-to-output path.
  assign intr   = (ps == ST_RUN) && mie_q && (|req);
  assign cause  = (ps == ST_ISR) ? cause_q : cause_run;
  assign in_isr = (ps == ST_ISR);

  always_comb begin
    ns   = ps;
    fire = 1'b0;
    case (ps)
      ST_RUN: begin
        if (taken && intr) begin
          fire = 1'b1;
          ns   = ST_ISR;
        end
      end
      ST_ISR: begin
        if (mret) ns = ST_RUN;
      end
      default: ns = ST_RUN;
    endcase
  end

  // The clear uses cause_run from the current mask, so a coincident mask_wr cannot redirect it.
  assign clr = fire ? (N_SRC'(1) << cause_run) : '0;

  always_ff @(posedge clk) begin
    if (RST) begin
      ps      <= ST_RUN;
      pending <= '0;
      mask    <= '0;
      cause_q <= '0;
      mie_q   <= 1'b0;
    end else begin
      ps      <= ns;
      mie_q   <= mie;
      pending <= (pending & ~clr) | rise;
      if (mask_wr) mask <= mask_data;
      if (fire) cause_q <= cause_run;
    end
  end

endmodule

// File: tb/tb_intr_ctrl.sv
// Scoreboard bench for intr_ctrl: directed stimulus queues expected outputs, a negedge monitor compares.
module tb_intr_ctrl;

  logic       clk = 1'b0;
  logic       RST;
  logic [7:0] irq_in;
  logic       mask_wr;
  logic [7:0] mask_data;
  logic       mie;
  logic       taken;
  logic       mret;
  logic       intr;
  logic [2:0] cause;
  logic [7:0] pending;
  logic       in_isr;

  typedef struct {
    string      name;
    logic       intr;
    logic [2:0] cause;
    logic [7:0] pending;
    logic       in_isr;
  } exp_t;

  exp_t exp_q[$];
  exp_t e_mon;
  int   n_cmp = 0;
  int   n_err = 0;

  intr_ctrl #(.N_SRC(8), .CW(3)) dut (
    .clk       (clk),
    .RST       (RST),
    .irq_in    (irq_in),
    .mask_wr   (mask_wr),
    .mask_data (mask_data),
    .mie       (mie),
    .taken     (taken),
    .mret      (mret),
    .intr      (intr),
    .cause     (cause),
    .pending   (pending),
    .in_isr    (in_isr)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    while (exp_q.size() > 0) begin
      e_mon = exp_q.pop_front();
      n_cmp++;
      if (intr !== e_mon.intr || cause !== e_mon.cause ||
          pending !== e_mon.pending || in_isr !== e_mon.in_isr) begin
        n_err++;
        $display("FAIL %s: got intr=%0b cause=%0d pending=%02h in_isr=%0b, want intr=%0b cause=%0d pending=%02h in_isr=%0b",
                 e_mon.name, intr, cause, pending, in_isr,
                 e_mon.intr, e_mon.cause, e_mon.pending, e_mon.in_isr);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string name, input logic i, input logic [2:0] c,
                            input logic [7:0] p, input logic s);
    exp_t e;
    e.name = name; e.intr = i; e.cause = c; e.pending = p; e.in_isr = s;
    exp_q.push_back(e);
  endtask

  task automatic load_mask(input logic [7:0] m);
    mask_wr = 1'b1; mask_data = m;
    step(1);
    mask_wr = 1'b0;
  endtask

  task automatic pulse_taken();
    taken = 1'b1; step(1); taken = 1'b0;
  endtask

  task automatic pulse_mret();
    mret = 1'b1; step(1); mret = 1'b0;
  endtask

  initial begin
    RST = 1'b1; irq_in = '0; mask_wr = 1'b0; mask_data = '0;
    mie = 1'b1; taken = 1'b0; mret = 1'b0;
    step(2);
    expect_out("reset", 0, 0, 8'h00, 0);
    RST = 1'b0;
    load_mask(8'hFF);

    // single source, latency and service
    irq_in = 8'h08;
    step(2);
    expect_out("irq3_lat2", 0, 0, 8'h00, 0);
    step(1);
    expect_out("irq3_lat3", 1, 3, 8'h08, 0);
    pulse_taken();
    expect_out("irq3_taken", 0, 3, 8'h00, 1);
    pulse_mret();
    expect_out("irq3_mret", 0, 0, 8'h00, 0);
    step(3);
    expect_out("level_held", 0, 0, 8'h00, 0);
    irq_in = '0; step(3);

    // priority between simultaneous sources
    irq_in = 8'h24;
    step(3);
    expect_out("prio_pend", 1, 2, 8'h24, 0);
    pulse_taken();
    expect_out("prio_take2", 0, 2, 8'h20, 1);
    pulse_mret();
    expect_out("prio_next5", 1, 5, 8'h20, 0);
    pulse_taken();
    expect_out("prio_take5", 0, 5, 8'h00, 1);
    pulse_mret();
    expect_out("prio_done", 0, 0, 8'h00, 0);
    irq_in = '0; step(3);

    // ignored strobes and taken+mret resolution
    taken = 1'b1; mret = 1'b1; step(1); taken = 1'b0; mret = 1'b0;
    expect_out("idle_strobes", 0, 0, 8'h00, 0);
    irq_in = 8'h01;
    step(3);
    expect_out("irq0_pend", 1, 0, 8'h01, 0);
    pulse_taken();
    expect_out("irq0_taken", 0, 0, 8'h00, 1);
    pulse_taken();
    expect_out("isr_taken_ign", 0, 0, 8'h00, 1);
    taken = 1'b1; mret = 1'b1; step(1); taken = 1'b0; mret = 1'b0;
    expect_out("isr_both", 0, 0, 8'h00, 0);
    irq_in = '0; step(3);

    // masked source, then unmasked
    load_mask(8'h00);
    irq_in = 8'h02;
    step(3);
    expect_out("masked_pend", 0, 0, 8'h02, 0);
    load_mask(8'h02);
    expect_out("unmasked", 1, 1, 8'h02, 0);
    pulse_taken();
    expect_out("unmask_take", 0, 1, 8'h00, 1);
    pulse_mret();
    irq_in = '0;
    load_mask(8'hFF);
    step(3);

    // mie gating
    mie = 1'b0; step(1);
    irq_in = 8'h40;
    step(3);
    expect_out("mie_off", 0, 6, 8'h40, 0);
    mie = 1'b1; step(1);
    expect_out("mie_on", 1, 6, 8'h40, 0);
    pulse_taken();
    pulse_mret();
    expect_out("mie_done", 0, 0, 8'h00, 0);
    irq_in = '0; step(3);

    // set wins over clear, then reset mid-handler and reset-release edge
    irq_in = 8'h10;
    step(3);
    expect_out("irq4_pend", 1, 4, 8'h10, 0);
    irq_in = 8'h00; step(1);
    irq_in = 8'h10; step(2);
    expect_out("irq4_before", 1, 4, 8'h10, 0);
    pulse_taken();
    expect_out("set_wins", 0, 4, 8'h10, 1);
    RST = 1'b1; step(1); RST = 1'b0;
    expect_out("rst_in_isr", 0, 0, 8'h00, 0);
    load_mask(8'hFF);
    expect_out("rel_e1", 0, 0, 8'h00, 0);
    step(1);
    expect_out("rel_e2", 0, 0, 8'h00, 0);
    step(1);
    expect_out("rel_e3", 1, 4, 8'h10, 0);
    pulse_taken();
    pulse_mret();
    irq_in = '0; step(3);

    // mask write coinciding with taken clears by old-mask cause
    irq_in = 8'h0A;
    step(3);
    expect_out("mw_pend", 1, 1, 8'h0A, 0);
    taken = 1'b1; mask_wr = 1'b1; mask_data = 8'h08;
    step(1);
    taken = 1'b0; mask_wr = 1'b0;
    expect_out("mw_take", 0, 1, 8'h08, 1);
    pulse_mret();
    expect_out("mw_next", 1, 3, 8'h08, 0);
    pulse_taken();
    expect_out("mw_take3", 0, 3, 8'h00, 1);
    pulse_mret();
    expect_out("mw_done", 0, 0, 8'h00, 0);

    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: got %0d entries left, want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
